// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the mem_bist memory self-test initiator.
// FSM state encoding, test phase sequence and the x*3 pattern step.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_REQ,
    ST_W_WAIT,
    ST_R_REQ,
    ST_R_WAIT,
    ST_GAP,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_WRITE,
    PH_READ,
    PH_WRITE_INV,
    PH_READ_INV
  } phase_t;

  localparam int ERR_CNT_W = 16;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  // Widest pattern the step helper handles; callers truncate to their own width.
  localparam int PAT_MAX_W = 64;

  function automatic logic [PAT_MAX_W-1:0] pat_step(input logic [PAT_MAX_W-1:0] x);
    return (x << 1) + x;
  endfunction

endpackage

// File: rtl/mem_bist_patgen.sv
// Test pattern generator: loads SEED, steps p(n+1)=p(n)*3 mod 2^W,
// and optionally presents the bitwise inverse of the current word.
module mem_bist_patgen
  import mem_bist_pkg::*;
#(
  parameter int          W    = 16,
  parameter logic [15:0] SEED = 16'h1010
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic         step_i,
  input  logic         inv_i,
  output logic [W-1:0] pat_o
);

  localparam logic [W-1:0] SEED_W = W'(SEED);

  logic [W-1:0] r_gen;
  logic [W-1:0] w_gen_step;

  assign w_gen_step = W'(pat_step(PAT_MAX_W'(r_gen)));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_gen <= SEED_W;
    end else if (load_i) begin
      r_gen <= SEED_W;
    end else if (step_i) begin
      r_gen <= w_gen_step;
    end
  end

  for (genvar gi = 0; gi < W; gi++) begin : g_inv
    assign pat_o[gi] = r_gen[gi] ^ inv_i;
  end

endmodule

// File: rtl/mem_bist.sv
// Memory BIST initiator for the memx host port: write pattern to every word, read back, report.
// Optional macro BIST_INV_PASS_EN adds a second write+read pass using the inverted pattern.
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter int          RAM_DATA_WIDTH = 16,
  parameter int          RAM_ADDR_WIDTH = 10,
  parameter int          RAM_N_OF_WORDS = 256,
  parameter logic [15:0] SEED           = 16'h1010,
  parameter int          TIMEOUT_CYC    = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      start_i,
  output logic                      mem_rd_o,
  output logic                      mem_wr_o,
  output logic [RAM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [RAM_DATA_WIDTH-1:0] mem_wdt_o,
  input  logic                      mem_busy_i,
  input  logic [RAM_DATA_WIDTH-1:0] mem_rdt_i,
  input  logic                      mem_wok_i,
  output logic                      running_o,
  output logic                      done_o,
  output logic                      pass_o,
  output logic                      timeout_o,
  output logic [ERR_CNT_W-1:0]      err_cnt_o,
  output logic [RAM_ADDR_WIDTH-1:0] fail_addr_o
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [RAM_ADDR_WIDTH-1:0] LAST_ADDR = RAM_ADDR_WIDTH'(RAM_N_OF_WORDS - 1);

  state_t r_state, w_next_state;
  phase_t r_phase, w_next_phase;

  logic [RAM_ADDR_WIDTH-1:0] r_addr;
  logic [RAM_ADDR_WIDTH-1:0] r_fail_addr;
  logic [ERR_CNT_W-1:0]      r_err_cnt;
  logic [TMO_W-1:0]          r_tmo_cnt;
  logic                      r_timeout;
  logic                      r_pass;

  logic [RAM_DATA_WIDTH-1:0] w_pat;
  logic w_phase_last, w_phase_rd, w_phase_inv, w_in_req;
  logic w_last_addr, w_tmo_hit, w_complete, w_cmp_err;
  logic w_gen_load, w_gen_step, w_wr, w_rd;

  mem_bist_patgen #(
    .W    (RAM_DATA_WIDTH),
    .SEED (SEED)
  ) u_patgen (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (w_gen_load),
    .step_i  (w_gen_step),
    .inv_i   (w_phase_inv),
    .pat_o   (w_pat)
  );

  always_comb begin
    w_next_phase = r_phase;
    w_phase_last = 1'b0;
    case (r_phase)
      PH_WRITE:     w_next_phase = PH_READ;
`ifdef BIST_INV_PASS_EN
      PH_READ:      w_next_phase = PH_WRITE_INV;
      PH_WRITE_INV: w_next_phase = PH_READ_INV;
`else
      PH_READ:      w_phase_last = 1'b1;
      PH_WRITE_INV: w_phase_last = 1'b1;
`endif
      PH_READ_INV:  w_phase_last = 1'b1;
      default:      w_phase_last = 1'b1;
    endcase
  end

  assign w_phase_rd  = (r_phase == PH_READ) || (r_phase == PH_READ_INV);
  assign w_phase_inv = (r_phase == PH_WRITE_INV) || (r_phase == PH_READ_INV);
  assign w_in_req    = (r_state == ST_W_REQ) || (r_state == ST_R_REQ);
  assign w_last_addr = (r_addr == LAST_ADDR);
  assign w_tmo_hit   = w_in_req && !mem_busy_i && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign w_complete  = ((r_state == ST_W_WAIT) || (r_state == ST_R_WAIT)) && !mem_busy_i;
  // A write fails on a missing write-ok, a read on any data difference.
  assign w_cmp_err   = (r_state == ST_W_WAIT) ? !mem_wok_i : (mem_rdt_i != w_pat);
  assign w_gen_load  = ((r_state == ST_IDLE) && start_i) || ((r_state == ST_GAP) && w_last_addr);
  assign w_gen_step  = (r_state == ST_GAP) && !w_last_addr;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start_i) w_next_state = ST_W_REQ;
      ST_W_REQ, ST_R_REQ: begin
        if (mem_busy_i) begin
          w_next_state = (r_state == ST_W_REQ) ? ST_W_WAIT : ST_R_WAIT;
        end else if (w_tmo_hit) begin
          w_next_state = ST_DONE;
        end
      end
      ST_W_WAIT, ST_R_WAIT: if (!mem_busy_i) w_next_state = ST_GAP;
      ST_GAP: begin
        if (!w_last_addr) begin
          w_next_state = w_phase_rd ? ST_R_REQ : ST_W_REQ;
        end else if (w_phase_last) begin
          w_next_state = ST_DONE;
        end else if ((w_next_phase == PH_READ) || (w_next_phase == PH_READ_INV)) begin
          w_next_state = ST_R_REQ;
        end else begin
          w_next_state = ST_W_REQ;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_wr        = (r_state == ST_W_REQ) || (r_state == ST_W_WAIT);
    w_rd        = (r_state == ST_R_REQ) || (r_state == ST_R_WAIT);
    mem_wr_o    = w_wr;
    mem_rd_o    = w_rd;
    mem_addr_o  = r_addr;
    mem_wdt_o   = w_wr ? w_pat : '0;
    running_o   = (r_state != ST_IDLE) && (r_state != ST_DONE);
    done_o      = (r_state == ST_DONE);
    pass_o      = r_pass;
    timeout_o   = r_timeout;
    err_cnt_o   = r_err_cnt;
    fail_addr_o = r_fail_addr;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_phase     <= PH_WRITE;
      r_addr      <= '0;
      r_fail_addr <= '0;
      r_err_cnt   <= '0;
      r_tmo_cnt   <= '0;
      r_timeout   <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_tmo_cnt <= (w_in_req && !mem_busy_i && !w_tmo_hit) ? r_tmo_cnt + TMO_W'(1) : '0;
      if (w_tmo_hit) r_timeout <= 1'b1;

      if ((r_state == ST_IDLE) && start_i) begin
        r_phase     <= PH_WRITE;
        r_addr      <= '0;
        r_fail_addr <= '0;
        r_err_cnt   <= '0;
        r_timeout   <= 1'b0;
        r_pass      <= 1'b0;
      end

      if (w_complete && w_cmp_err) begin
        if (r_err_cnt == '0) r_fail_addr <= r_addr;
        if (r_err_cnt != ERR_CNT_MAX) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end

      if (r_state == ST_GAP) begin
        if (w_last_addr) begin
          r_addr  <= '0;
          r_phase <= w_next_phase;
        end else begin
          r_addr <= r_addr + RAM_ADDR_WIDTH'(1);
        end
      end

      // Verdict is latched on entry to DONE so it is valid alongside done_o.
      if (w_next_state == ST_DONE) begin
        r_pass <= (r_err_cnt == '0) && !r_timeout && !w_tmo_hit;
      end
    end
  end

endmodule
